// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART-to-bus debug bridge.
//   state_t     : bridge FSM states
//   resp_kind_t : which reply the RESP state is sending
//   frame_t     : command frame assembled from the UART byte stream
//   is_cmd()    : true for a recognised command byte
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WR,
        RD,
        RDWAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        RK_ACK,
        RK_NAK,
        RK_READ
    } resp_kind_t;

    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } frame_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/bus_if.sv
// Simple 32-bit memory bus. The slave returns rdata one cycle after ren.
//   master: drives wen/waddr/wdata and ren/raddr, samples rdata
//   slave : the mirror image
interface bus_if;
    logic        wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;

    modport master (output wen, waddr, wdata, ren, raddr, input rdata);
    modport slave  (input wen, waddr, wdata, ren, raddr, output rdata);
endinterface

// File: rtl/uart_bridge_timeout.sv
// Inter-byte timeout counter.
//   clk, rst : clock, async active-high reset
//   clear    : zero the counter (takes priority over enable)
//   enable   : count one idle clock
//   expired  : counter has reached TIMEOUT_CYCLES-1 (holds there until cleared)
module uart_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_WIDTH       = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_WIDTH-1:0] LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_WIDTH-1:0] cnt_q;

    assign expired = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable && !expired)
            cnt_q <= cnt_q + TO_WIDTH'(1);
    end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART-driven bus initiator for debug/program loading.
// Frames: 57 A0..A3 D0..D3 -> write, reply 06
//         52 A0..A3         -> read,  reply R0..R3 (little-endian)
//         other first byte  -> reply 15, err set
// Ports:
//   clk, rst          : clock, async active-high reset
//   rx_data, rx_tick  : received byte and its one-cycle strobe
//   tx_data, tx_valid : reply byte, held stable until tx_ready
//   tx_ready          : reply sink accepts on valid&ready
//   bus               : bus_if master (one outstanding access)
//   busy              : FSM not in IDLE
//   err               : sticky dropped-byte / bad-command / timeout flag
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_WIDTH       = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_tick,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    bus_if.master      bus,
    output logic       busy,
    output logic       err
);

    state_t     state_q, state_d;
    frame_t     frame_q;
    logic [1:0] byte_cnt_q;
    logic [1:0] resp_idx_q;
    resp_kind_t resp_kind_q;
    logic [31:0] rd_word_q;
    logic       err_q;
    logic [7:0] resp_byte;
    logic       resp_last;
    logic       in_frame;
    logic       drop_state;
    logic       to_expired;

    assign in_frame   = (state_q == ADDR) || (state_q == DATA);
    assign drop_state = (state_q == WR) || (state_q == RD) ||
                        (state_q == RDWAIT) || (state_q == RESP);

    // Counter only runs between bytes of a frame; any byte restarts it.
    uart_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_WIDTH       (TO_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_frame || rx_tick),
        .enable  (in_frame && !rx_tick),
        .expired (to_expired)
    );

    // Response byte mux
    always_comb begin
        resp_byte = 8'h00;
        case (resp_kind_q)
            RK_ACK:  resp_byte = RSP_ACK;
            RK_NAK:  resp_byte = RSP_NAK;
            RK_READ: resp_byte = rd_word_q[{resp_idx_q, 3'b000} +: 8];
            default: resp_byte = 8'h00;
        endcase
    end

    assign resp_last = (resp_kind_q != RK_READ) || (resp_idx_q == 2'd3);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state. In ADDR/DATA a byte beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:
                if (rx_tick)
                    state_d = is_cmd(rx_data) ? ADDR : RESP;
            ADDR:
                if (rx_tick) begin
                    if (byte_cnt_q == 2'd3)
                        state_d = frame_q.is_write ? DATA : RD;
                end else if (to_expired) begin
                    state_d = IDLE;
                end
            DATA:
                if (rx_tick) begin
                    if (byte_cnt_q == 2'd3)
                        state_d = WR;
                end else if (to_expired) begin
                    state_d = IDLE;
                end
            WR:      state_d = RESP;
            RD:      state_d = RDWAIT;
            RDWAIT:  state_d = RESP;
            RESP:
                if (tx_ready && resp_last)
                    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.wen  = (state_q == WR);
        bus.ren  = (state_q == RD);
        busy     = (state_q != IDLE);
        tx_valid = (state_q == RESP);
        tx_data  = (state_q == RESP) ? resp_byte : 8'h00;
    end

    assign bus.waddr = frame_q.addr;
    assign bus.wdata = frame_q.data;
    assign bus.raddr = frame_q.addr;
    assign err       = err_q;

    // Frame assembly and reply bookkeeping. Address/data shift in from the
    // top so the first byte received ends up as the least significant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q     <= '0;
            byte_cnt_q  <= '0;
            resp_idx_q  <= '0;
            resp_kind_q <= RK_ACK;
            rd_word_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    byte_cnt_q <= '0;
                    resp_idx_q <= '0;
                    if (rx_tick) begin
                        frame_q.is_write <= (rx_data == CMD_WRITE);
                        if (!is_cmd(rx_data)) begin
                            resp_kind_q <= RK_NAK;
                            err_q       <= 1'b1;
                        end
                    end
                end
                ADDR:
                    if (rx_tick) begin
                        frame_q.addr <= {rx_data, frame_q.addr[31:8]};
                        byte_cnt_q   <= byte_cnt_q + 2'd1;
                    end else if (to_expired) begin
                        byte_cnt_q <= '0;
                        err_q      <= 1'b1;
                    end
                DATA:
                    if (rx_tick) begin
                        frame_q.data <= {rx_data, frame_q.data[31:8]};
                        byte_cnt_q   <= byte_cnt_q + 2'd1;
                    end else if (to_expired) begin
                        byte_cnt_q <= '0;
                        err_q      <= 1'b1;
                    end
                WR:
                    resp_kind_q <= RK_ACK;
                RDWAIT: begin
                    rd_word_q   <= bus.rdata;
                    resp_kind_q <= RK_READ;
                end
                RESP:
                    if (tx_ready)
                        resp_idx_q <= resp_idx_q + 2'd1;
                default: ;
            endcase
            // Bytes arriving while a command is in flight are discarded.
            if (rx_tick && drop_state)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_tick = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       err;

    bus_if bus_i ();

    uart_bus_bridge #(
        .TIMEOUT_CYCLES (16),
        .TO_WIDTH       (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_tick  (rx_tick),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus      (bus_i),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int asserts = 0;
    int fails   = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    logic [7:0] exp_tx[$];
    bus_exp_t   exp_bus[$];

    // Power-on contents of the 16-word slave; word 8 (addr 0x20) is 12345678.
    function automatic logic [31:0] init_word(input logic [3:0] i);
        if (i == 4'd8) return 32'h12345678;
        return 32'hC0DE_0000 | ({28'd0, i} << 8) | ({28'd0, i} * 32'd17);
    endfunction

    // Slave: 16 words decoded from addr[5:2], one-cycle read latency.
    logic [31:0] slave_mem [16];
    logic [15:0] slave_written = '0;
    always @(posedge clk) begin
        if (bus_i.wen) begin
            slave_mem[bus_i.waddr[5:2]]     <= bus_i.wdata;
            slave_written[bus_i.waddr[5:2]] <= 1'b1;
        end
        if (bus_i.ren)
            bus_i.rdata <= slave_written[bus_i.raddr[5:2]] ? slave_mem[bus_i.raddr[5:2]]
                                                          : init_word(bus_i.raddr[5:2]);
    end

    // Reference memory: what a correct bridge would have left in the slave.
    logic [31:0] model_mem [16];
    logic [15:0] model_written = '0;
    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_written[a[5:2]] ? model_mem[a[5:2]] : init_word(a[5:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        asserts++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // 0: random ready, 1: held low, 2: always high
    int ready_mode = 2;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = ($urandom_range(0, 3) != 0);
            1:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
        endcase
    end

    // tx monitor: pops on each accepted byte, checks hold while stalled
    logic       hold_pending = 1'b0;
    logic [7:0] held = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, tx_data}, {24'd0, held});
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) flag("tx_unexpected_byte");
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
            hold_pending <= tx_valid && !tx_ready;
            held         <= tx_data;
        end
    end

    // bus monitor: one expected access per wen/ren cycle
    always @(negedge clk) begin
        if (!rst && (bus_i.wen || bus_i.ren)) begin
            chk("wen_ren_exclusive", {31'd0, bus_i.wen && bus_i.ren}, 32'd0);
            if (exp_bus.size() == 0) begin
                flag("bus_unexpected_access");
            end else begin
                bus_exp_t e;
                e = exp_bus.pop_front();
                chk("bus_is_write", {31'd0, bus_i.wen}, {31'd0, e.is_wr});
                chk("bus_addr", bus_i.wen ? bus_i.waddr : bus_i.raddr, e.addr);
                if (e.is_wr) chk("bus_wdata", bus_i.wdata, e.data);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_tick = 1'b1;
        @(posedge clk); #1;
        rx_tick = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    function automatic int pick_gap(input bit rnd);
        return rnd ? int'($urandom_range(0, 3)) : 0;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input bit rnd, input int cmd_gap);
        bus_exp_t e;
        e.is_wr = 1'b1; e.addr = a; e.data = d;
        exp_bus.push_back(e);
        exp_tx.push_back(8'h06);
        model_mem[a[5:2]]     = d;
        model_written[a[5:2]] = 1'b1;
        send_byte(8'h57, cmd_gap);
        for (int k = 0; k < 4; k++) send_byte(8'((a >> (8 * k)) & 32'hFF), pick_gap(rnd));
        for (int k = 0; k < 4; k++) send_byte(8'((d >> (8 * k)) & 32'hFF), (k == 3) ? 0 : pick_gap(rnd));
    endtask

    task automatic do_read(input logic [31:0] a, input bit rnd);
        bus_exp_t    e;
        logic [31:0] w;
        w = model_read(a);
        e.is_wr = 1'b0; e.addr = a; e.data = 32'd0;
        exp_bus.push_back(e);
        for (int k = 0; k < 4; k++) exp_tx.push_back(8'((w >> (8 * k)) & 32'hFF));
        send_byte(8'h52, pick_gap(rnd));
        for (int k = 0; k < 4; k++) send_byte(8'((a >> (8 * k)) & 32'hFF), (k == 3) ? 0 : pick_gap(rnd));
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(name, {31'd0, done}, 32'd1);
        if (!done) begin
            exp_tx.delete();
            exp_bus.delete();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] bad;
        int         r;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_wen_ren", {30'd0, bus_i.wen, bus_i.ren}, 32'd0);
        chk("rst_waddr", bus_i.waddr, 32'd0);
        chk("rst_wdata", bus_i.wdata, 32'd0);
        chk("rst_raddr", bus_i.raddr, 32'd0);
        chk("rst_busy_err", {30'd0, busy, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: write, wen on the 2nd edge after D3, ACK the edge after
        ready_mode = 2;
        do_write(32'h10, 32'hDEADBEEF, 1'b0, 0);
        chk("t1_wen_high", {31'd0, bus_i.wen}, 32'd1);
        @(posedge clk); #1;
        chk("t1_wen_one_cycle", {31'd0, bus_i.wen}, 32'd0);
        chk("t1_ack_valid", {31'd0, tx_valid}, 32'd1);
        chk("t1_ack_data", {24'd0, tx_data}, 32'h06);
        wait_idle("t1_done");
        chk("t1_busy_err", {30'd0, busy, err}, 32'd0);

        // 2: read, R0 appears two edges after ren
        do_read(32'h20, 1'b0);
        chk("t2_ren_high", {31'd0, bus_i.ren}, 32'd1);
        chk("t2_raddr", bus_i.raddr, 32'h20);
        @(posedge clk); #1;
        chk("t2_ren_one_cycle", {31'd0, bus_i.ren}, 32'd0);
        chk("t2_rdwait_no_valid", {31'd0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t2_r0_valid", {31'd0, tx_valid}, 32'd1);
        chk("t2_r0_data", {24'd0, tx_data}, 32'h78);
        wait_idle("t2_done");

        // 3: sink stalls for 100 cycles; a stray byte is dropped meanwhile
        ready_mode = 1;
        do_read(32'h10, 1'b1);
        repeat (100) begin @(posedge clk); #1; end
        chk("t3_stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("t3_stall_data", {24'd0, tx_data}, 32'hEF);
        chk("t3_err_clean", {31'd0, err}, 32'd0);
        send_byte(8'h57, 0);
        chk("t3_drop_err", {31'd0, err}, 32'd1);
        chk("t3_drop_busy", {31'd0, busy}, 32'd1);
        ready_mode = 0;
        wait_idle("t3_done");

        // 4: bad command -> NAK, err, no bus access
        pulse_reset();
        chk("t4_err_cleared", {31'd0, err}, 32'd0);
        exp_tx.push_back(8'h15);
        send_byte(8'hAA, 0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        wait_idle("t4_done");
        chk("t4_err", {31'd0, err}, 32'd1);

        // 5: timeout after 16 idle clocks, no reply; then a normal write
        pulse_reset();
        send_byte(8'h57, 0);
        send_byte(8'h10, 15);
        chk("t5_busy_before_expiry", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("t5_idle_after_expiry", {31'd0, busy}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_no_reply", {31'd0, tx_valid}, 32'd0);
        do_write($urandom, $urandom, 1'b1, 0);
        wait_idle("t5_write_after_timeout");

        // 5b: byte arriving on the expiry cycle wins
        pulse_reset();
        do_write($urandom, $urandom, 1'b0, 15);
        wait_idle("t5b_done");
        chk("t5b_no_err", {31'd0, err}, 32'd0);

        // 6: reset mid-DATA, then a clean read
        send_byte(8'h57, 0);
        for (int k = 0; k < 6; k++) send_byte(8'($urandom), 0);
        rst = 1'b1;
        #1;
        chk("t6_wen", {31'd0, bus_i.wen}, 32'd0);
        chk("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_read(32'h20, 1'b1);
        wait_idle("t6_read_after_reset");

        // Random traffic
        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                do_write($urandom, $urandom, 1'b1, int'($urandom_range(0, 3)));
            end else if (r < 8) begin
                do_read($urandom, 1'b1);
            end else begin
                bad = 8'($urandom);
                if (bad == 8'h57 || bad == 8'h52) bad = 8'hFF;
                exp_tx.push_back(8'h15);
                send_byte(bad, 0);
            end
            wait_idle("rand_cmd_done");
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
